// File: rtl/ex_mem_pipeline_register.sv
// EX/MEM pipeline register with a 2-entry skid buffer behind a valid/ready handshake.
// The main slot drives mem_* directly. ex_ready is a flop, so no ready path runs through combinationally.
module ex_mem_pipeline_register #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_data_top,
  input  logic [DATA_W-1:0]     ex_data_bot,
  input  logic [REG_ADDR_W-1:0] ex_rd_top,
  input  logic [REG_ADDR_W-1:0] ex_rd_bot,
  input  logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_data_top,
  output logic [DATA_W-1:0]     mem_data_bot,
  output logic [REG_ADDR_W-1:0] mem_rd_top,
  output logic [REG_ADDR_W-1:0] mem_rd_bot,
  output logic [CTRL_W-1:0]     mem_ctrl
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     data_top;
    logic [DATA_W-1:0]     data_bot;
    logic [REG_ADDR_W-1:0] rd_top;
    logic [REG_ADDR_W-1:0] rd_bot;
    logic [CTRL_W-1:0]     ctrl;
  } slot_t;

  state_t state, state_next;
  slot_t  main_q, main_next;
  slot_t  skid_q, skid_next;
  slot_t  in_slot;
  logic   accept;
  logic   issue;

  assign in_slot = '{data_top: ex_data_top, data_bot: ex_data_bot,
                     rd_top: ex_rd_top, rd_bot: ex_rd_bot, ctrl: ex_ctrl};

  assign mem_valid = (state != EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign issue     = mem_valid & mem_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_next  = in_slot;
        end
      end
      ONE: begin
        if (accept && issue) begin
          main_next = in_slot;
        end else if (accept) begin
          state_next = TWO;
          skid_next  = in_slot;
        end else if (issue) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (issue) begin
          state_next = ONE;
          main_next  = skid_q;
        end
      end
      default: state_next = EMPTY;
    endcase
    // A flush drops whatever was accepted this cycle. Slot contents may go stale.
    if (flush) state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= EMPTY;
      // NOTE: data slots are cleared on reset because the outputs must read zero after reset.
      main_q   <= '0;
      skid_q   <= '0;
      ex_ready <= 1'b1;
    end else begin
      state    <= state_next;
      main_q   <= main_next;
      skid_q   <= skid_next;
      ex_ready <= (state_next != TWO);
    end
  end

  assign mem_data_top = main_q.data_top;
  assign mem_data_bot = main_q.data_bot;
  assign mem_rd_top   = main_q.rd_top;
  assign mem_rd_bot   = main_q.rd_bot;
  assign mem_ctrl     = main_q.ctrl & {CTRL_W{mem_valid}};

endmodule
